// File: rtl/mdu_pkg.sv
// Shared constants for the RV32M multi-cycle multiply/divide sequencer:
// funct3 op codes, FSM state encoding, parameter bounds and special-case values.
package mdu_pkg;

  localparam logic [2:0] SEL_GROUP_MDU = 3'b001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  localparam int MUL_STAGES_MIN = 1;
  localparam int MUL_STAGES_MAX = 4;
  localparam int DIV_STEPS      = 32;

  localparam logic [31:0] ALL_ONES   = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN = 32'h8000_0000;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3 inside {F3_REM, F3_REMU};
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring radix-2 divider on unsigned 32-bit operands; loaded by
// start, advances one quotient bit per step cycle.
module mdu_div_core (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dsr_q;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Partial remainder with the next dividend bit shifted in; a borrow out of
  // the trial subtraction means this quotient bit is 0 and nothing is restored.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dsr_q};
  end

  // NOTE: registers update with <= so every read in this block sees the
  // pre-edge value, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (step) begin
      quo_q <= {quo_q[30:0], ~diff[32]};
      rem_q <= diff[32] ? shifted[31:0] : diff[31:0];
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide controller with registered result and DONE pulse.
// Define MDU_DIV_EARLY_OUT_EN to short-cut divide-by-zero and signed overflow to FIX.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int XLEN       = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [5:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  if (MUL_STAGES < MUL_STAGES_MIN || MUL_STAGES > MUL_STAGES_MAX || XLEN != 32) begin : g_bad_params
    $error("mdu_sequencer: unsupported MUL_STAGES or XLEN");
  end

`ifdef MDU_DIV_EARLY_OUT_EN
  localparam logic EARLY_OUT = 1'b1;
`else
  localparam logic EARLY_OUT = 1'b0;
`endif

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        q_neg, r_neg, div_zero, div_ovf, pend;
  logic        done_q;
  logic [31:0] result_q;

  logic        accept, legal, sel_div, sel_sdiv, zero_in, ovf_in, early;
  logic        div_start, div_step;
  logic [31:0] dividend_in, divisor_in, quotient, remainder;
  logic [63:0] a64, b64, prod;
  logic [31:0] mul_res, q_fix, r_fix, fix_res;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    legal       = SELECT[5:3] == SEL_GROUP_MDU;
    accept      = START && !FLUSH && state == ST_IDLE;
    sel_div     = is_div_op(SELECT[2:0]);
    sel_sdiv    = SELECT[2:0] inside {F3_DIV, F3_REM};
    zero_in     = DATA2 == '0;
    ovf_in      = sel_sdiv && DATA1 == SIGNED_MIN && DATA2 == ALL_ONES;
    early       = EARLY_OUT && (zero_in || ovf_in);
    dividend_in = sel_sdiv ? abs32(DATA1) : DATA1;
    divisor_in  = sel_sdiv ? abs32(DATA2) : DATA2;
    div_start   = accept && legal && sel_div;
  end

  always_comb begin
    state_next = state;
    div_step   = 1'b0;
    case (state)
      ST_IDLE: if (accept && legal) state_next = sel_div ? (early ? ST_FIX : ST_DIV) : ST_MUL;
      ST_MUL:  if (cnt == '0) state_next = ST_IDLE;
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt == '0) state_next = ST_FIX;
      end
      ST_FIX:  if (cnt == '0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (FLUSH) state_next = ST_IDLE;
  end

  // 33x33 signed product, sign-extended to 64 bits; the low 64 bits are exact.
  always_comb begin
    a64     = {{32{opa[31] & (op inside {F3_MULH, F3_MULHSU})}}, opa};
    b64     = {{32{opb[31] & (op == F3_MULH)}}, opb};
    prod    = a64 * b64;
    mul_res = (op inside {F3_MULH, F3_MULHSU, F3_MULHU}) ? prod[63:32] : prod[31:0];
  end

  always_comb begin
    q_fix = q_neg ? -quotient : quotient;
    r_fix = r_neg ? -remainder : remainder;
    if (div_zero) begin
      q_fix = ALL_ONES;
      r_fix = opa;
    end else if (div_ovf) begin
      q_fix = SIGNED_MIN;
      r_fix = '0;
    end
    fix_res = is_rem_op(op) ? r_fix : q_fix;
  end

  mdu_div_core u_div (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (div_start),
    .step      (div_step),
    .dividend  (dividend_in),
    .divisor   (divisor_in),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt      <= '0;
      op       <= '0;
      opa      <= '0;
      opb      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      pend     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (FLUSH) begin
      cnt    <= '0;
      pend   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend   <= 1'b0;
      // An illegal SELECT completes one edge after it is seen, without BUSY.
      if (pend) begin
        result_q <= '0;
        done_q   <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept && !legal) begin
            pend <= 1'b1;
          end else if (accept) begin
            op       <= SELECT[2:0];
            opa      <= DATA1;
            opb      <= DATA2;
            q_neg    <= sel_sdiv && (DATA1[31] ^ DATA2[31]);
            r_neg    <= sel_sdiv && DATA1[31];
            div_zero <= sel_div && zero_in;
            div_ovf  <= sel_div && ovf_in;
            if (!sel_div)  cnt <= 5'(MUL_STAGES - 1);
            else if (early) cnt <= 5'd1;
            else            cnt <= 5'(DIV_STEPS - 1);
          end
        end
        ST_MUL: begin
          if (cnt == '0) begin
            result_q <= mul_res;
            done_q   <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_DIV: if (cnt != '0) cnt <= cnt - 5'd1;
        ST_FIX: begin
          if (cnt == '0) begin
            result_q <= fix_res;
            done_q   <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign BUSY   = state != ST_IDLE;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle controller for the RV32M multiply/divide operations. The single-cycle ALU's combinational multiply and divide cannot meet the pipeline clock, so these operations are handed to this block instead. It accepts one operation at a time from the EX stage, computes it in a fixed, known number of cycles, and returns a registered result with a one-cycle DONE pulse. The hazard unit holds the pipeline while BUSY is high.

## Interface
Parameters:
- MUL_STAGES, 2: cycles from the accept edge to the DONE edge for MUL/MULH/MULHSU/MULHU; legal range 1..4.
- XLEN, 32: operand width; only 32 is supported.

Ports:
- CLK  in  1  clock. Single clock domain.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request; qualified by SELECT, DATA1, DATA2 in the same cycle.
- SELECT  in  6  operation code using the ALU encoding {3'b001, funct3}.
  - funct3 values: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  in  32  rs1 operand.
- DATA2  in  32  rs2 operand.
- FLUSH  in  1  aborts any in-flight operation.
- BUSY  out  1  high when the state is not IDLE.
- DONE  out  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  out  32  registered result; holds its value until the next DONE.

## Operation
States: IDLE, MUL, DIV, FIX.

IDLE:
- On START=1 and FLUSH=0, latch the operands and decode SELECT.
- SELECT[5:3]≠001: no state change; RESULT←0 and DONE=1 at the next edge.
- Multiply op → MUL; a cycle counter is loaded with MUL_STAGES-1.
- Divide op → DIV; the counter is loaded with 31.
  - DIV/REM: latch |DATA1| and |DATA2| plus the quotient and remainder signs.
  - DIVU/REMU: latch raw values.

MUL:
- Compute a 33x33 signed product from sign- or zero-extended operands: MULH s×s, MULHSU s×u, MULHU u×u.
- MUL returns product[31:0]; MULH* return product[63:32].
- When the counter reaches 0: register RESULT, pulse DONE, go to IDLE.

DIV:
- Restoring radix-2 division, one quotient bit per cycle, 32 cycles.
- Counter reaches 0 → FIX.

FIX:
- Apply signs: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Select quotient or remainder by op.
- Special cases override the computed value:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = DATA1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Register RESULT, pulse DONE, go to IDLE.

Boundary conditions:
- START while BUSY: ignored; operands are not relatched.
- START in the same cycle as DONE: accepted, because the state is already IDLE.
- FLUSH in any state: next state is IDLE, no DONE, RESULT unchanged.
- FLUSH and START together: FLUSH wins; the request is not accepted.
- RESET mid-operation: same as FLUSH, and outputs also go to their reset values.

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0.
- The accept edge is edge 0. BUSY rises after edge 0 and falls in the DONE cycle.
- Multiply: DONE after edge MUL_STAGES.
- Divide: DONE after edge 33 (32 DIV edges plus 1 FIX edge).
- Illegal SELECT: DONE after edge 1, BUSY never asserted.
- Back-to-back operations: issue interval equals latency; there are no idle bubbles.

## Configuration
MDU_DIV_EARLY_OUT_EN:
- Defined: a divide by zero or signed-overflow case detected at accept goes directly to FIX, so DONE comes after edge 2.
- Undefined: these cases take the full 33 cycles.
- Results are bit-identical either way; only latency changes.

## Structure
- Package mdu_pkg: funct3 op constants, state encoding, MUL_STAGES bounds, special-case constants (0xFFFFFFFF, 0x80000000).
- Sub-module mdu_div_core: the iterative restoring divider (shift/subtract registers and quotient accumulation). It is started and stepped by the sequencer FSM.
- Multiply, sign handling and FIX logic stay in mdu_sequencer.

## Test plan
- MUL 0x00000007 × 0xFFFFFFFD → RESULT 0xFFFFFFEB; MULH same operands → 0xFFFFFFFF; MULHU same operands → 0x00000006; DONE after edge MUL_STAGES.
- DIV 0xFFFFFFEC / 0x00000003 → 0xFFFFFFFA; REM → 0xFFFFFFFE; DIVU 100/7 → 14; REMU → 2; DONE after edge 33; BUSY high for 33 cycles.
- DIV x/0 with DATA1=0x12345678 → 0xFFFFFFFF; REMU x/0 → 0x12345678; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Check latency 2 with the macro defined and 33 without.
- START held high during a DIV with changing operands → first result unaffected; the second op is accepted in the DONE cycle.
- FLUSH at cycle 10 of a DIV → BUSY low next cycle, no DONE, RESULT keeps its prior value. RESET mid-MUL → all outputs 0.
- SELECT 6'b000000 with START → DONE after edge 1 with RESULT 0, BUSY never high.
